// File: rtl/ddr3_cmd_engine.sv
// ddr3_cmd_engine: DDR3 BFM command decoder, bank tracker, MR0/MR1/MR2 capture and latency-matched beat strobes.
// Define DDR3_TIMING_CHECK_EN to build per-bank tRCD/tRP/tRAS checking onto o_err_timing.
module ddr3_cmd_engine #(
  parameter int BA_W    = 3,
  parameter int ROW_W   = 13,
  parameter int COL_W   = 10,
  parameter int MAX_LAT = 24,
  parameter int DEF_CL  = 5,
  parameter int DEF_CWL = 5,
  parameter int DEF_AL  = 0,
  parameter int T_RCD   = 5,
  parameter int T_RP    = 5,
  parameter int T_RAS   = 15
) (
  input  logic                         i_ck,
  input  logic                         i_reset_n,
  input  logic                         i_cke,
  input  logic                         i_cs_n,
  input  logic                         i_ras_n,
  input  logic                         i_cas_n,
  input  logic                         i_we_n,
  input  logic [BA_W-1:0]              i_ba,
  input  logic [15:0]                  i_a,
  output logic                         o_rd_beat,
  output logic [BA_W+ROW_W+COL_W-1:0]  o_rd_addr,
  output logic                         o_rd_last,
  output logic                         o_wr_beat,
  output logic [BA_W+ROW_W+COL_W-1:0]  o_wr_addr,
  output logic                         o_wr_last,
  output logic [4:0]                   o_cl,
  output logic [4:0]                   o_cwl,
  output logic [4:0]                   o_al,
  output logic                         o_err_cmd,
  output logic                         o_err_ovl,
  output logic                         o_err_mrs,
  output logic                         o_err_timing
);
  localparam int NBANK = 2**BA_W;
  localparam int AW = BA_W + ROW_W + COL_W;
  localparam int LW = $clog2(MAX_LAT);
  logic [NBANK-1:0] r_open;
  logic [ROW_W-1:0] r_row [NBANK];
  logic [4:0] r_cl, r_cwl, r_al;
  logic [1:0] r_alm, r_bl;
  logic r_err_cmd, r_err_ovl, r_err_mrs;
  logic [MAX_LAT-1:0][AW+1:0] r_pipe [2];
  logic [1:0] r_cnt [2];
  logic [1:0] r_beat, r_last;
  logic [AW-1:0] r_addr [2];
  logic [2:0] w_cmd;
  logic w_act, w_pre, w_ref, w_mrs, w_rw, w_open, w_len, w_mrs_bad;
  logic [1:0] w_go;
  logic [LW-1:0] w_slot [2];
  logic [NBANK-1:0] w_sel, w_close;
  logic [AW-1:0] w_addr;
  logic [4:0] w_cl_n, w_cwl_n, w_al_n;
  logic [1:0] w_alm_n, w_bl_n;
  logic w_unused;
  assign w_unused = ^i_a[15:13];
  always_comb begin
    w_cmd = i_cke && !i_cs_n ? {i_ras_n, i_cas_n, i_we_n} : 3'b111;
    w_act = w_cmd == 3'b011;
    w_pre = w_cmd == 3'b010;
    w_ref = w_cmd == 3'b001;
    w_mrs = w_cmd == 3'b000;
    w_rw = w_cmd[2:1] == 2'b10;
    w_open = r_open[i_ba];
    w_go = {w_cmd == 3'b100, w_cmd == 3'b101} & {2{w_open}};
    w_sel = NBANK'(1) << i_ba;
    w_close = w_pre ? (i_a[10] ? '1 : w_sel) : (|w_go && i_a[10] ? w_sel : '0);
    w_len = r_bl == 2'b00 || (r_bl == 2'b01 && i_a[12]);
    w_addr = {i_ba, r_row[i_ba], i_a[COL_W-1:0]};
    w_slot[0] = LW'(r_al + r_cl - 5'd1);
    w_slot[1] = LW'(r_al + r_cwl - 5'd1);
    w_cl_n = r_cl;
    w_cwl_n = r_cwl;
    w_alm_n = r_alm;
    w_bl_n = r_bl;
    w_mrs_bad = 1'b0;
    case (i_ba[1:0])
      2'd0: begin
        w_cl_n = 5'(i_a[6:4]) + 5'd4;
        w_bl_n = i_a[1:0];
        w_mrs_bad = i_a[2] || i_a[6:4] == 3'd0 || &i_a[1:0];
      end
      2'd1: begin
        w_alm_n = i_a[4:3];
        w_mrs_bad = &i_a[4:3];
      end
      2'd2: w_cwl_n = 5'(i_a[5:3]) + 5'd5;
      default: ;
    endcase
    // AL modes CL-1 / CL-2 follow later CL changes
    w_al_n = w_alm_n == 2'd1 ? w_cl_n - 5'd1 : w_alm_n == 2'd2 ? w_cl_n - 5'd2 : i_ba[1:0] == 2'd1 ? 5'd0 : r_al;
    w_mrs_bad = w_mrs_bad || int'(w_al_n) + int'(w_cl_n) > MAX_LAT || int'(w_al_n) + int'(w_cwl_n) > MAX_LAT;
  end
  always_ff @(posedge i_ck) begin
    if (!i_reset_n) begin
      r_open <= '0;
      r_cl <= 5'(DEF_CL);
      r_cwl <= 5'(DEF_CWL);
      r_al <= 5'(DEF_AL);
      r_alm <= 2'd0;
      r_bl <= 2'd0;
      r_err_cmd <= 1'b0;
      r_err_mrs <= 1'b0;
    end else begin
      r_open <= (r_open & ~w_close) | (w_act ? w_sel : '0);
      if (w_act) r_row[i_ba] <= i_a[ROW_W-1:0];
      if ((w_act && w_open) || (w_rw && !w_open) || (w_ref && |r_open)) r_err_cmd <= 1'b1;
      if (w_mrs && w_mrs_bad) r_err_mrs <= 1'b1;
      if (w_mrs && !w_mrs_bad) begin
        r_cl <= w_cl_n;
        r_cwl <= w_cwl_n;
        r_al <= w_al_n;
        r_alm <= w_alm_n;
        r_bl <= w_bl_n;
      end
    end
  end
  always_ff @(posedge i_ck) begin
    if (!i_reset_n) begin
      r_beat <= '0;
      r_last <= '0;
      r_err_ovl <= 1'b0;
      for (int d = 0; d < 2; d++) begin
        r_pipe[d] <= '0;
        r_cnt[d] <= '0;
        r_addr[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        r_pipe[d] <= r_pipe[d] >> (AW + 2);
        if (w_go[d]) r_pipe[d][w_slot[d]] <= {1'b1, w_len, w_addr};
        if (r_pipe[d][0][AW+1]) begin
          r_beat[d] <= 1'b1;
          r_last[d] <= 1'b0;
          r_addr[d] <= r_pipe[d][0][AW-1:0];
          r_cnt[d] <= r_pipe[d][0][AW] ? 2'd3 : 2'd1;
          if (r_cnt[d] != 2'd0) r_err_ovl <= 1'b1;
        end else if (r_cnt[d] != 2'd0) begin
          r_last[d] <= r_cnt[d] == 2'd1;
          r_addr[d][2:0] <= r_addr[d][2:0] + 3'd2;
          r_cnt[d] <= r_cnt[d] - 2'd1;
        end else begin
          r_beat[d] <= 1'b0;
          r_last[d] <= 1'b0;
        end
      end
    end
  end
`ifdef DDR3_TIMING_CHECK_EN
  logic [7:0] r_rcd [NBANK];
  logic [7:0] r_rp [NBANK];
  logic [7:0] r_ras [NBANK];
  logic r_err_timing;
  logic w_viol;
  always_comb begin
    w_viol = (w_act && r_rp[i_ba] != 8'd0) || (|w_go && r_rcd[i_ba] != 8'd0);
    for (int b = 0; b < NBANK; b++)
      w_viol = w_viol || (w_pre && w_close[b] && r_open[b] && r_ras[b] != 8'd0);
  end
  always_ff @(posedge i_ck) begin
    if (!i_reset_n) begin
      r_err_timing <= 1'b0;
      for (int b = 0; b < NBANK; b++) begin
        r_rcd[b] <= '0;
        r_rp[b] <= '0;
        r_ras[b] <= '0;
      end
    end else begin
      if (w_viol) r_err_timing <= 1'b1;
      for (int b = 0; b < NBANK; b++) begin
        r_rcd[b] <= w_act && w_sel[b] ? 8'(T_RCD - 1) : r_rcd[b] - 8'(r_rcd[b] != 8'd0);
        r_ras[b] <= w_act && w_sel[b] ? 8'(T_RAS - 1) : r_ras[b] - 8'(r_ras[b] != 8'd0);
        r_rp[b] <= w_close[b] && r_open[b] ? 8'(T_RP - 1) : r_rp[b] - 8'(r_rp[b] != 8'd0);
      end
    end
  end
  assign o_err_timing = r_err_timing;
`else
  logic w_unused_t;
  assign w_unused_t = ^(T_RCD ^ T_RP ^ T_RAS);
  assign o_err_timing = 1'b0;
`endif
  assign o_rd_beat = r_beat[0];
  assign o_rd_last = r_last[0];
  assign o_rd_addr = r_addr[0];
  assign o_wr_beat = r_beat[1];
  assign o_wr_last = r_last[1];
  assign o_wr_addr = r_addr[1];
  assign o_cl = r_cl;
  assign o_cwl = r_cwl;
  assign o_al = r_al;
  assign o_err_cmd = r_err_cmd;
  assign o_err_ovl = r_err_ovl;
  assign o_err_mrs = r_err_mrs;
endmodule

// File: tb/tb_ddr3_cmd_engine.sv
// tb_ddr3_cmd_engine: directed vectors for ddr3_cmd_engine with hand-computed beat timing and addresses.
module tb_ddr3_cmd_engine;
  localparam logic [3:0] MRS = 4'b0000, PRE = 4'b0010, ACT = 4'b0011, WR = 4'b0100, RD = 4'b0101;
  logic ck, reset_n, cke, cs_n, ras_n, cas_n, we_n;
  logic [2:0] ba;
  logic [15:0] a;
  logic rd_beat, rd_last, wr_beat, wr_last;
  logic [25:0] rd_addr, wr_addr;
  logic [4:0] cl, cwl, al;
  logic err_cmd, err_ovl, err_mrs, err_timing;
  int n_vec, n_err;
  ddr3_cmd_engine dut (
    .i_ck(ck), .i_reset_n(reset_n), .i_cke(cke), .i_cs_n(cs_n), .i_ras_n(ras_n),
    .i_cas_n(cas_n), .i_we_n(we_n), .i_ba(ba), .i_a(a),
    .o_rd_beat(rd_beat), .o_rd_addr(rd_addr), .o_rd_last(rd_last),
    .o_wr_beat(wr_beat), .o_wr_addr(wr_addr), .o_wr_last(wr_last),
    .o_cl(cl), .o_cwl(cwl), .o_al(al),
    .o_err_cmd(err_cmd), .o_err_ovl(err_ovl), .o_err_mrs(err_mrs), .o_err_timing(err_timing)
  );
  initial ck = 1'b0;
  always #5 ck = ~ck;
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout, expected summary");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge ck);
  endtask
  task automatic issue(input logic [3:0] c, input logic [2:0] b, input logic [15:0] adr);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b;
    a = adr;
    @(negedge ck);
    {cs_n, ras_n, cas_n, we_n} = 4'b0111;
  endtask
  task automatic burst(input string tag, input bit wr, input int lat, input int len,
                       input logic [2:0] b, input logic [12:0] row, input logic [9:0] col);
    logic [9:0] c;
    bit on;
    for (int k = 1; k <= lat + len; k++) begin
      idle(1);
      on = k >= lat && k < lat + len;
      c = {col[9:3], 3'(col[2:0] + 3'(2 * (k - lat)))};
      chk({tag, "_beat"}, wr ? wr_beat : rd_beat, on);
      chk({tag, "_last"}, wr ? wr_last : rd_last, on && k == lat + len - 1);
      if (on) chk({tag, "_addr"}, wr ? wr_addr : rd_addr, {b, row, c});
    end
  endtask
  initial begin
    logic [9:0] c;
    bit on;
    reset_n = 1'b0;
    cke = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = 4'b0111;
    ba = '0;
    a = '0;
    idle(3);
    chk("rst_rd_beat", rd_beat, 0);
    chk("rst_wr_beat", wr_beat, 0);
    chk("rst_cl", cl, 5);
    chk("rst_cwl", cwl, 5);
    chk("rst_al", al, 0);
    chk("rst_errs", {err_cmd, err_ovl, err_mrs, err_timing}, 0);
    reset_n = 1'b1;
    issue(MRS, 0, 16'h0020);
    issue(MRS, 1, 16'h0000);
    chk("t1_cl6", cl, 6);
    chk("t1_al0", al, 0);
    issue(ACT, 2, 16'h01A5);
    idle(4);
    issue(RD, 2, 16'h0010);
    burst("t1_rd", 0, 6, 4, 3'd2, 13'h1A5, 10'h010);
    issue(MRS, 0, 16'h0021);
    chk("t2_cl_kept", cl, 6);
    chk("t2_no_err_mrs", err_mrs, 0);
    issue(ACT, 0, 16'h0033);
    idle(4);
    issue(WR, 0, 16'h0006);
    burst("t2_wr", 1, 5, 2, 3'd0, 13'h033, 10'h006);
    chk("t2_no_err_cmd", err_cmd, 0);
    issue(RD, 5, 16'h0000);
    chk("t3_rd_closed", err_cmd, 1);
    burst("t3_dropped", 0, 7, 0, 3'd5, 13'h0, 10'h0);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    chk("t3_rst_err_cmd", err_cmd, 0);
    cke = 1'b0;
    issue(RD, 6, 16'h0000);
    cke = 1'b1;
    chk("t3_cke0_ignored", err_cmd, 0);
    issue(ACT, 2, 16'h0001);
    issue(ACT, 5, 16'h0002);
    idle(16);
    issue(PRE, 0, 16'h0400);
    idle(5);
    issue(ACT, 5, 16'h0003);
    chk("t3_act_after_pall", err_cmd, 0);
    issue(ACT, 5, 16'h0004);
    chk("t3_act_open", err_cmd, 1);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    issue(MRS, 1, 16'h0008);
    chk("t4_al_cl_m1", al, 4);
    issue(ACT, 3, 16'h0ABC);
    idle(4);
    issue(RD, 3, 16'h0008);
    idle(3);
    issue(RD, 3, 16'h0020);
    for (int k = 5; k <= 17; k++) begin
      idle(1);
      on = k >= 9 && k <= 16;
      c = k <= 12 ? 10'(8 + 2 * (k - 9)) : 10'(32 + 2 * (k - 13));
      chk("t4_b2b_beat", rd_beat, on);
      chk("t4_b2b_last", rd_last, k == 12 || k == 16);
      if (on) chk("t4_b2b_addr", rd_addr, {3'd3, 13'h0ABC, c});
    end
    chk("t4_no_ovl", err_ovl, 0);
    issue(RD, 3, 16'h0000);
    idle(1);
    issue(RD, 3, 16'h0040);
    idle(9);
    chk("t4_ovl", err_ovl, 1);
    chk("t4_new_wins", rd_addr, {3'd3, 13'h0ABC, 10'h040});
    idle(6);
    issue(MRS, 0, 16'h0020);
    chk("t5_cl6", cl, 6);
    chk("t5_al_tracks", al, 5);
    issue(MRS, 0, 16'h0000);
    chk("t5_err_mrs", err_mrs, 1);
    chk("t5_cl_kept", cl, 6);
    issue(MRS, 1, 16'h0018);
    chk("t5_al_kept", al, 5);
    issue(MRS, 2, 16'h0018);
    chk("t5_cwl8", cwl, 8);
    issue(ACT, 4, 16'h0100);
    idle(4);
    issue(RD, 4, 16'h0000);
    idle(12);
    chk("t5_mid_burst", rd_beat, 1);
    reset_n = 1'b0;
    idle(1);
    chk("t5_rst_abort", rd_beat, 0);
    chk("t5_rst_cl", cl, 5);
    chk("t5_rst_cwl", cwl, 5);
    chk("t5_rst_al", al, 0);
    chk("t5_rst_errs", {err_mrs, err_ovl}, 0);
    reset_n = 1'b1;
    idle(3);
    chk("t5_stay_idle", rd_beat, 0);
    chk("t6_pre_timing", err_timing, 0);
    issue(ACT, 1, 16'h0055);
    idle(1);
    issue(RD, 1, 16'h0018);
`ifdef DDR3_TIMING_CHECK_EN
    chk("t6_err_timing", err_timing, 1);
`else
    chk("t6_err_timing", err_timing, 0);
`endif
    burst("t6_rd", 0, 5, 4, 3'd1, 13'h0055, 10'h018);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
